// File: rtl/gpio_arb_pkg.sv
// Shared types and defaults for the GPIO output arbiter.
// The optional macro GPIO_ARB_DIR_MASK_EN (used in gpio_out_arbiter.sv) masks
// output-value commands with the direction register.
package gpio_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 2;
    localparam int WIDTH_DEFAULT   = 32;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_DIR   = 2'b11
    } gpio_op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Generic round-robin arbiter: combinational grant from the valid vector and
// a registered "last granted" pointer, advanced only when the grant is taken.
// After reset requester 0 has first priority.
module gpio_rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         valid,
    input  logic                 accept,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_reg;
    logic [IW-1:0] cand;

    // Search from the requester after the last grant, wrapping around, and
    // take the first one that is valid.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            if (!grant_any) begin
                cand = IW'((int'(last_reg) + i) % N);
                if (valid[cand]) begin
                    grant_any   = 1'b1;
                    grant_idx   = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

    // Remember the winner once the grant is consumed; reset points at N-1 so
    // the first search starts at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= IW'(N - 1);
        end else if (accept && grant_any) begin
            last_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/gpio_out_arbiter.sv
// Round-robin sequencer sharing the GPIO output datapath between requesters.
// IDLE accepts one command (ready is combinational), ISSUE applies it for one
// cycle; shadow/direction update and set/clr pulses appear after ISSUE.
// Optional macro GPIO_ARB_DIR_MASK_EN: WRITE/SET/CLR touch only output pins.
module gpio_out_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int WIDTH   = WIDTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [2*NUM_REQ-1:0]       req_op_i,
    input  logic [WIDTH*NUM_REQ-1:0]   req_data_i,
    output logic [WIDTH-1:0]           gpio_output_o,
    output logic [WIDTH-1:0]           gpio_output_set_o,
    output logic [WIDTH-1:0]           gpio_output_clr_o,
    output logic [WIDTH-1:0]           gpio_direction_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e       state_reg, state_next;
    gpio_op_e         op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [IW-1:0]    grant_id_reg;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [WIDTH-1:0] dir_reg, dir_next;
    logic [WIDTH-1:0] set_reg, set_next;
    logic [WIDTH-1:0] clr_reg, clr_next;
    logic [WIDTH-1:0] dir_mask;
    logic [WIDTH-1:0] masked;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;
    logic               accept;

    gpio_op_e         op_arr   [NUM_REQ];
    logic [WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_arr[gi]   = gpio_op_e'(req_op_i[2*gi +: 2]);
        assign data_arr[gi] = req_data_i[WIDTH*gi +: WIDTH];
    end

`ifdef GPIO_ARB_DIR_MASK_EN
    assign dir_mask = dir_reg;
`else
    assign dir_mask = '1;
`endif

    gpio_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk       (clk_i),
        .rst       (rst_i),
        .valid     (req_valid_i),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake: grant only in IDLE, ISSUE always lasts one cycle.
    always_comb begin
        state_next  = state_reg;
        req_ready_o = '0;
        accept      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (grant_any) begin
                    req_ready_o = grant;
                    accept      = 1'b1;
                    state_next  = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Capture the accepted command and the winner's index.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_reg       <= OP_WRITE;
            data_reg     <= '0;
            grant_id_reg <= '0;
        end else if (accept) begin
            op_reg       <= op_arr[grant_idx];
            data_reg     <= data_arr[grant_idx];
            grant_id_reg <= grant_idx;
        end
    end

    // Apply the latched command during ISSUE; pulses default to zero.
    always_comb begin
        out_next = out_reg;
        dir_next = dir_reg;
        set_next = '0;
        clr_next = '0;
        masked   = data_reg & dir_mask;
        if (state_reg == S_ISSUE) begin
            case (op_reg)
                OP_WRITE: out_next = (out_reg & ~dir_mask) | masked;
                OP_SET: begin
                    out_next = out_reg | masked;
                    set_next = masked;
                end
                OP_CLR: begin
                    out_next = out_reg & ~masked;
                    clr_next = masked;
                end
                OP_DIR:  dir_next = data_reg;
                default: ;
            endcase
        end
    end

    // Shadow, direction and pulse registers; reset clears any pending pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_reg <= '0;
            dir_reg <= '0;
            set_reg <= '0;
            clr_reg <= '0;
        end else begin
            out_reg <= out_next;
            dir_reg <= dir_next;
            set_reg <= set_next;
            clr_reg <= clr_next;
        end
    end

    assign gpio_output_o     = out_reg;
    assign gpio_output_set_o = set_reg;
    assign gpio_output_clr_o = clr_reg;
    assign gpio_direction_o  = dir_reg;
    assign grant_id_o        = grant_id_reg;
    assign busy_o            = (state_reg == S_ISSUE);

endmodule

// File: tb/tb_gpio_out_arbiter.sv
// Scoreboard bench for gpio_out_arbiter (NUM_REQ=2, WIDTH=32). Stimulus pushes
// the hand-computed result of each command; the monitor pops and compares in
// the cycle after ISSUE. Honors GPIO_ARB_DIR_MASK_EN for the masked cases.
module tb_gpio_out_arbiter;
    import gpio_arb_pkg::*;

    localparam int NR = 2;
    localparam int W  = 32;

`ifdef GPIO_ARB_DIR_MASK_EN
    localparam logic [31:0] WR_ALL_EXP    = 32'h0000_FFFF;
    localparam logic [31:0] CLR_PULSE_EXP = 32'h0000_FFFF;
`else
    localparam logic [31:0] WR_ALL_EXP    = 32'hFFFF_FFFF;
    localparam logic [31:0] CLR_PULSE_EXP = 32'hFFFF_FFFF;
`endif

    logic              clk   = 1'b0;
    logic              rst_i = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [2*NR-1:0]   req_op = '0;
    logic [W*NR-1:0]   req_data = '0;
    logic [W-1:0]      gpio_out, gpio_set, gpio_clr, gpio_dir;
    logic [0:0]        grant_id;
    logic              busy;

    gpio_out_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_data_i        (req_data),
        .gpio_output_o     (gpio_out),
        .gpio_output_set_o (gpio_set),
        .gpio_output_clr_o (gpio_clr),
        .gpio_direction_o  (gpio_dir),
        .grant_id_o        (grant_id),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:0]  gid;
        logic [31:0] out;
        logic [31:0] set;
        logic [31:0] clr;
        logic [31:0] dir;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   prev_busy = 1'b0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, expv);
        end
    endtask

    task automatic push(input logic [0:0] gid, input logic [31:0] out, input logic [31:0] set,
                        input logic [31:0] clr, input logic [31:0] dir);
        exp_t e;
        e.gid = gid; e.out = out; e.set = set; e.clr = clr; e.dir = dir;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int k, input gpio_op_e op, input logic [31:0] data);
        req_op[2*k +: 2]   = op;
        req_data[W*k +: W] = data;
        req_valid[k]       = 1'b1;
    endtask

    // Present one command and hold it until ready, then release after the edge.
    task automatic send(input int k, input gpio_op_e op, input logic [31:0] data);
        bit got;
        got = 1'b0;
        @(negedge clk);
        drive(k, op, data);
        for (int c = 0; c < 16 && !got; c++) begin
            #1;
            if (req_ready[k]) got = 1'b1;
            else @(negedge clk);
        end
        if (got) begin
            check("ready_onehot", 32'(req_ready), 32'(1 << k));
            @(posedge clk);
            #1;
            req_valid[k] = 1'b0;
        end else begin
            tests++; fails++;
            $display("FAIL ready_timeout req=%0d actual=0 expected=1", k);
            req_valid[k] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 16 && !idle; c++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) begin
            tests++; fails++;
            $display("FAIL idle_timeout actual=busy expected=idle");
        end
    endtask

    // Monitor: the cycle after ISSUE carries the result of one command.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_txn actual=out 0x%08h expected=no transaction", gpio_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("[TB] txn gid=%0d out=0x%08h set=0x%08h clr=0x%08h dir=0x%08h",
                             grant_id, gpio_out, gpio_set, gpio_clr, gpio_dir);
                    check("grant_id", 32'(grant_id), 32'(mon_e.gid));
                    check("shadow_out", gpio_out, mon_e.out);
                    check("set_pulse", gpio_set, mon_e.set);
                    check("clr_pulse", gpio_clr, mon_e.clr);
                    check("direction", gpio_dir, mon_e.dir);
                end
            end else begin
                check("pulse_idle", gpio_set | gpio_clr, 32'h0);
            end
            check("pulse_exclusive", gpio_set & gpio_clr, 32'h0);
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #1;
        check("rst_out", gpio_out, 32'h0);
        check("rst_dir", gpio_dir, 32'h0);
        check("rst_pulses", gpio_set | gpio_clr, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        // Single-requester sequence.
        push(1'b1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        send(1, OP_DIR, 32'hFFFF_FFFF);
        push(1'b0, 32'h0000_00F0, 32'h0000_00F0, 32'h0, 32'hFFFF_FFFF);
        send(0, OP_SET, 32'h0000_00F0);
        push(1'b0, 32'h0000_00C0, 32'h0, 32'h0000_0030, 32'hFFFF_FFFF);
        send(0, OP_CLR, 32'h0000_0030);
        push(1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hFFFF_FFFF);
        send(1, OP_WRITE, 32'hDEAD_BEEF);

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        wait_idle();
        push(1'b0, 32'h1111_1111, 32'h0, 32'h0, 32'hFFFF_FFFF);
        push(1'b1, 32'h2222_2222, 32'h0, 32'h0, 32'hFFFF_FFFF);
        push(1'b0, 32'h1111_1111, 32'h0, 32'h0, 32'hFFFF_FFFF);
        push(1'b1, 32'h2222_2222, 32'h0, 32'h0, 32'hFFFF_FFFF);
        drive(0, OP_WRITE, 32'h1111_1111);
        drive(1, OP_WRITE, 32'h2222_2222);
        for (int cyc = 0; cyc < 8; cyc++) begin
            logic [1:0] er;
            if (cyc > 0) @(negedge clk);
            #1;
            er = (cyc % 2 != 0) ? 2'b00 : ((cyc % 4 == 0) ? 2'b01 : 2'b10);
            check("rr_ready", 32'(req_ready), 32'(er));
            if (cyc == 7) req_valid = '0;
        end

        // Valid raised during ISSUE is held off, then accepted exactly once.
        wait_idle();
        push(1'b0, 32'h1234_5678, 32'h0, 32'h0, 32'hFFFF_FFFF);
        push(1'b1, 32'h1234_5608, 32'h0, 32'h0000_0070, 32'hFFFF_FFFF);
        drive(0, OP_WRITE, 32'h1234_5678);
        #1;
        check("held_ready0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        drive(1, OP_CLR, 32'h0000_0070);
        #1;
        check("held_off", 32'(req_ready), 32'h0);
        @(negedge clk);
        #1;
        check("held_ready1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;

        // Zero data, direction masking and masked pulses.
        push(1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        send(0, OP_WRITE, 32'h0);
        push(1'b1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        send(1, OP_SET, 32'h0);
        push(1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_FFFF);
        send(0, OP_DIR, 32'h0000_FFFF);
        push(1'b1, WR_ALL_EXP, 32'h0, 32'h0, 32'h0000_FFFF);
        send(1, OP_WRITE, 32'hFFFF_FFFF);
        push(1'b0, 32'h0, 32'h0, CLR_PULSE_EXP, 32'h0000_FFFF);
        send(0, OP_CLR, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of ISSUE aborts the command.
        wait_idle();
        drive(1, OP_SET, 32'h0000_00A5);
        #1;
        check("abort_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("abort_busy_before", 32'(busy), 32'h1);
        #1;
        rst_i = 1'b1;
        #1;
        check("async_rst_out", gpio_out, 32'h0);
        check("async_rst_dir", gpio_dir, 32'h0);
        check("async_rst_pulses", gpio_set | gpio_clr, 32'h0);
        check("async_rst_gid", 32'(grant_id), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        #1;
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_out", gpio_out, 32'h0);
        check("post_rst_pulses", gpio_set | gpio_clr, 32'h0);

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
